dbus_responder: RTL

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/dbus_pkg.sv | 47 ++++
 rtl/dbus_ram.sv | 33 +++
 rtl/dbus_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared widths, func3 encodings, FSM states and load extension for the data bus responder
package dbus_pkg;

    localparam int XLEN       = 32;
    localparam int ADDR_W     = 32;
    localparam int BYTE_LANES = XLEN / 8;
    localparam int CNT_W      = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Pick the addressed byte/half out of a RAM word and sign- or zero-extend it.
    function automatic logic [XLEN-1:0] load_extend(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    load_extend = {{24{b[7]}}, b};
            F3_BU:   load_extend = {24'd0, b};
            F3_H:    load_extend = {{16{h[15]}}, h};
            F3_HU:   load_extend = {16'd0, h};
            F3_W:    load_extend = word;
            default: load_extend = '0;
        endcase
    endfunction

endpackage

// File: rtl/dbus_ram.sv
// rtl/dbus_ram.sv - single-port word RAM with byte write strobes and registered read
module dbus_ram
    import dbus_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [BYTE_LANES-1:0] be,
    input  logic [AW-1:0]         addr,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // Byte-masked write and read-before-write registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < BYTE_LANES; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - wait-stated RV32I data bus slave backed by a byte-strobed RAM
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int P_DEPTH_WORDS = 1024,
    parameter int P_WAIT_STATES = 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_DBUS_Re,
    input  logic              i_DBUS_We,
    input  logic [2:0]        i_DBUS_Func3,
    input  logic [ADDR_W-1:0] i_DBUS_Addr,
    input  logic [XLEN-1:0]   i_DBUS_WData,
    output logic [XLEN-1:0]   o_DBUS_RData,
    output logic              o_DBUS_Ack,
    output logic              o_DBUS_Fault
);

    localparam int AW = $clog2(P_DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_INIT =
        (P_WAIT_STATES > 0) ? CNT_W'(P_WAIT_STATES - 1) : '0;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    capture;
    logic                    fault_in;

    logic                    req_re, req_we, req_fault;
    logic [2:0]              req_f3;
    logic [AW+1:0]           req_addr;
    logic [XLEN-1:0]         req_wdata;

    logic                    ram_en;
    logic [BYTE_LANES-1:0]   ram_be;
    logic [XLEN-1:0]         ram_wdata, ram_rdata;

    // Classify the incoming request as faulting before it is captured.
    always_comb begin
        fault_in = 1'b0;
        if (i_DBUS_Re && i_DBUS_We) begin
            fault_in = 1'b1;
        end else if (i_DBUS_Re && (i_DBUS_Func3 == 3'b011 || i_DBUS_Func3[2:1] == 2'b11)) begin
            fault_in = 1'b1;
        end else if (i_DBUS_We && (i_DBUS_Func3[2] || i_DBUS_Func3 == 3'b011)) begin
            fault_in = 1'b1;
        end
        if (i_DBUS_Func3[1:0] == 2'b01 && i_DBUS_Addr[0]) begin
            fault_in = 1'b1;
        end
        if (i_DBUS_Func3[1:0] == 2'b10 && i_DBUS_Addr[1:0] != 2'b00) begin
            fault_in = 1'b1;
        end
        if (i_DBUS_Addr[ADDR_W-1:2] >= (ADDR_W-2)'(P_DEPTH_WORDS)) begin
            fault_in = 1'b1;
        end
    end

    // Next-state logic: capture in IDLE, count wait states, one access, one response cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_DBUS_Re || i_DBUS_We) begin
                    capture = 1'b1;
                    if (P_WAIT_STATES == 0) begin
                        state_nxt = ST_ACCESS;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_ACCESS;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request latch; bus inputs are ignored after capture until the next IDLE.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            req_re    <= 1'b0;
            req_we    <= 1'b0;
            req_fault <= 1'b0;
            req_f3    <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (capture) begin
            req_re    <= i_DBUS_Re;
            req_we    <= i_DBUS_We;
            req_fault <= fault_in;
            req_f3    <= i_DBUS_Func3;
            req_addr  <= i_DBUS_Addr[AW+1:0];
            req_wdata <= i_DBUS_WData;
        end
    end

    // Lane strobes and lane-replicated store data for the latched request.
    always_comb begin
        ram_be    = '0;
        ram_wdata = req_wdata;
        case (req_f3)
            F3_B: begin
                ram_be    = BYTE_LANES'(1) << req_addr[1:0];
                ram_wdata = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                ram_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{req_wdata[15:0]}};
            end
            F3_W:    ram_be = 4'b1111;
            default: ram_be = '0;
        endcase
    end

    // Reset at the ACCESS edge must suppress the write, so enable is gated by reset.
    assign ram_en = (state == ST_ACCESS) && i_Rst_n && !req_fault;

    dbus_ram #(
        .DEPTH (P_DEPTH_WORDS)
    ) u_ram (
        .clk   (i_Clk),
        .en    (ram_en),
        .we    (req_we),
        .be    (ram_be),
        .addr  (req_addr[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Response outputs are forced to zero everywhere except the RESP cycle.
    always_comb begin
        o_DBUS_Ack   = (state == ST_RESP);
        o_DBUS_Fault = (state == ST_RESP) && req_fault;
        o_DBUS_RData = '0;
        if (state == ST_RESP && !req_fault && req_re) begin
            o_DBUS_RData = load_extend(req_f3, req_addr[1:0], ram_rdata);
        end
    end

endmodule
